// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl
//   Parametrised SRAM burst controller. Runs strided write and read-compare
//   passes against a synchronous SRAM and reports the mismatch count together
//   with the address and data of the first failing read.
//
// Ports
//   clk, reset_n          system clock, synchronous active-low reset
//   start, mode           launch pulse and operation select
//                         (00 write, 01 compare, 10 write+compare, 11 no-op)
//   sta_addr, length      first address, accesses per pass minus one
//   stride, dir, wrap     step minus one, 0 up / 1 down, modulo addressing
//   pat_inc, pattern      data seed and per-access increment enable
//   busy, done, trunc     status: in progress, completion pulse, pass cut short
//   err_cnt               saturating mismatch count
//   fail_addr, fail_data  first mismatch address and read data
//   s_*                   SRAM pins (strobe polarity set by ACT_LOW)
//   led_hb                heartbeat, toggles every LED_DIV+1 cycles
module sram_bist_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RD_LAT  = 1,
    parameter bit          ACT_LOW = 1'b1,
    parameter logic [31:0] LED_DIV = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] sta_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] stride,
    input  logic              dir,
    input  logic              wrap,
    input  logic              pat_inc,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              trunc,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    input  logic [DATA_W-1:0] s_qdata,
    output logic [DATA_W-1:0] s_ddata,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_cen,
    output logic              s_wen,
    output logic              s_oen,
    output logic              s_clk,
    output logic              led_hb
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic       STB_ON     = ACT_LOW ? 1'b0 : 1'b1;
    localparam logic       STB_OFF    = ~STB_ON;
    localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] sta_q, sta_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              dir_q, dir_d;
    logic              wrap_q, wrap_d;
    logic              pinc_q, pinc_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [2:0]        drain_q, drain_d;
    logic              trunc_q, trunc_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [31:0]       div_q, div_d;
    logic              led_q, led_d;

    logic              start_acc;
    logic [ADDR_W:0]   step_w;
    logic [ADDR_W:0]   nxt_w;
    logic              last_acc;
    logic              out_rng;
    logic              issue_rd;

    // Expected read data/address travel beside the SRAM read latency.
    logic [DATA_W-1:0] exp_data_p [RD_LAT];
    logic [ADDR_W-1:0] exp_addr_p [RD_LAT];
    logic [RD_LAT-1:0] vld_p;
    logic              mism;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign issue_rd  = (state_q == ST_READ);

    // One extra bit exposes leaving the address space in either direction:
    // carry on increment, borrow (sign) on decrement.
    assign step_w   = {1'b0, stride_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign nxt_w    = dir_q ? ({1'b0, addr_q} - step_w) : ({1'b0, addr_q} + step_w);
    assign last_acc = (k_q == len_q);
    assign out_rng  = !wrap_q && nxt_w[ADDR_W];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sta_d    = sta_q;
        len_d    = len_q;
        stride_d = stride_q;
        dir_d    = dir_q;
        wrap_d   = wrap_q;
        pinc_d   = pinc_q;
        pat_d    = pat_q;
        addr_d   = addr_q;
        data_d   = data_q;
        k_d      = k_q;
        drain_d  = drain_q;
        trunc_d  = trunc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    sta_d    = sta_addr;
                    len_d    = length;
                    stride_d = stride;
                    dir_d    = dir;
                    wrap_d   = wrap;
                    pinc_d   = pat_inc;
                    pat_d    = pattern;
                    addr_d   = sta_addr;
                    data_d   = pattern;
                    k_d      = '0;
                    trunc_d  = 1'b0;
                    case (mode)
                        2'b00, 2'b10: state_d = ST_WRITE;
                        2'b01:        state_d = ST_READ;
                        default:      state_d = ST_DONE;
                    endcase
                end
            end
            ST_WRITE, ST_READ: begin
                if (last_acc || out_rng) begin
                    if (!last_acc) begin
                        trunc_d = 1'b1;
                    end
                    if (state_q == ST_READ) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end else if (mode_q == 2'b10) begin
                        // Compare pass replays the same address/data sequence.
                        state_d = ST_READ;
                        addr_d  = sta_q;
                        data_d  = pat_q;
                        k_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    addr_d = nxt_w[ADDR_W-1:0];
                    data_d = pinc_q ? data_q + 1'b1 : data_q;
                    k_d    = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mism = vld_p[RD_LAT-1] && (s_qdata != exp_data_p[RD_LAT-1]);

    always_comb begin
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (start_acc) begin
            err_d       = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mism) begin
            // A zero count means no earlier mismatch in this operation.
            if (err_q == 16'd0) begin
                fail_addr_d = exp_addr_p[RD_LAT-1];
                fail_data_d = s_qdata;
            end
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    always_comb begin
        div_d = div_q + 32'd1;
        led_d = led_q;
        if (div_q == LED_DIV) begin
            div_d = '0;
            led_d = ~led_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            sta_q       <= '0;
            len_q       <= '0;
            stride_q    <= '0;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            pinc_q      <= 1'b0;
            pat_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            trunc_q     <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            div_q       <= '0;
            led_q       <= 1'b0;
            vld_p       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sta_q       <= sta_d;
            len_q       <= len_d;
            stride_q    <= stride_d;
            dir_q       <= dir_d;
            wrap_q      <= wrap_d;
            pinc_q      <= pinc_d;
            pat_q       <= pat_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            trunc_q     <= trunc_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            div_q       <= div_d;
            led_q       <= led_d;
            vld_p[0]    <= issue_rd;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Pipeline payload carries no reset; only vld_p qualifies it.
    always_ff @(posedge clk) begin
        exp_data_p[0] <= data_q;
        exp_addr_p[0] <= addr_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            exp_data_p[i] <= exp_data_p[i-1];
            exp_addr_p[i] <= exp_addr_p[i-1];
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign trunc     = trunc_q;
    assign err_cnt   = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign s_addr    = addr_q;
    assign s_ddata   = data_q;
    assign s_cen     = (state_q == ST_WRITE || state_q == ST_READ) ? STB_ON : STB_OFF;
    assign s_wen     = (state_q == ST_WRITE) ? STB_ON : STB_OFF;
    assign s_oen     = (state_q == ST_READ) ? STB_ON : STB_OFF;
    assign s_clk     = clk;
    assign led_hb    = led_q;

endmodule
